// File: rtl/asg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : asg_pkg
// Brief    : Shared state encoding, trigger codes, constants and a saturation
//            helper for the asg_interp_ch signal-generator channel.
// Revision : 1.0
// ============================================================================
package asg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DELAY = 2'd2
    } asg_state_e;

    localparam logic [2:0] TRIG_OFF       = 3'd0;
    localparam logic [2:0] TRIG_SW        = 3'd1;
    localparam logic [2:0] TRIG_EXT_RISE  = 3'd2;
    localparam logic [2:0] TRIG_EXT_FALL  = 3'd3;
    localparam logic [2:0] TRIG_EXT_LEVEL = 3'd4;
    localparam logic [2:0] TRIG_ALWAYS    = 3'd5;

    localparam int WGT_W        = 8;
    localparam int PIPE_LAT     = 6;
    localparam int DEBOUNCE_CNT = 62500;

    // Clamp a sign-extended value into the w-bit two's complement range.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] x,
                                                      input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi)      return hi;
        else if (x < lo) return lo;
        else             return x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/asg_trig_cond.sv
`default_nettype none
// ============================================================================
// Module   : asg_trig_cond
// Brief    : External trigger synchroniser and edge detect, optional lockout
//            (macro ASG_EXT_DEBOUNCE_EN), and trigger source selection.
// Revision : 1.0
// ============================================================================
module asg_trig_cond
    import asg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trig_sw,
    input  logic       trig_ext,
    input  logic [2:0] trig_src,
    output logic       trig
);

    logic ext_s1;
    logic ext_s2;
    logic ext_s3;
    logic rise_raw;
    logic fall_raw;
    logic ext_rise;
    logic ext_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_s1 <= 1'b0;
            ext_s2 <= 1'b0;
            ext_s3 <= 1'b0;
        end else begin
            ext_s1 <= trig_ext;
            ext_s2 <= ext_s1;
            ext_s3 <= ext_s2;
        end
    end

    assign rise_raw = ext_s2 & ~ext_s3;
    assign fall_raw = ~ext_s2 & ext_s3;

`ifdef ASG_EXT_DEBOUNCE_EN
    localparam int LOCK_W = $clog2(DEBOUNCE_CNT + 1);

    logic [LOCK_W-1:0] rise_lock;
    logic [LOCK_W-1:0] fall_lock;

    assign ext_rise = rise_raw && (rise_lock == '0);
    assign ext_fall = fall_raw && (fall_lock == '0);

    // Each polarity has its own lockout window, started by an accepted edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_lock <= '0;
            fall_lock <= '0;
        end else begin
            if (ext_rise)
                rise_lock <= LOCK_W'(DEBOUNCE_CNT);
            else if (rise_lock != '0)
                rise_lock <= rise_lock - LOCK_W'(1);
            if (ext_fall)
                fall_lock <= LOCK_W'(DEBOUNCE_CNT);
            else if (fall_lock != '0)
                fall_lock <= fall_lock - LOCK_W'(1);
        end
    end
`else
    assign ext_rise = rise_raw;
    assign ext_fall = fall_raw;
`endif

    always_comb begin
        trig = 1'b0;
        case (trig_src)
            TRIG_OFF:       trig = 1'b0;
            TRIG_SW:        trig = trig_sw;
            TRIG_EXT_RISE:  trig = ext_rise;
            TRIG_EXT_FALL:  trig = ext_fall;
            TRIG_EXT_LEVEL: trig = ext_s2;
            TRIG_ALWAYS:    trig = 1'b1;
            default:        trig = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/asg_interp_ch.sv
`default_nettype none
// ============================================================================
// Module   : asg_interp_ch
// Brief    : ASG channel: phase-accumulated table playback with optional linear
//            interpolation, bursts and delayed repetitions. Build option:
//            ASG_EXT_DEBOUNCE_EN (external trigger lockout, in asg_trig_cond).
// Revision : 1.0
// ============================================================================
module asg_interp_ch
    import asg_pkg::*;
#(
    parameter int DW         = 14,
    parameter int RSZ        = 14,
    parameter int FRAC       = 16,
    parameter int CYCLE_BITS = 32,
    parameter int TICK_DIV   = 125
) (
    input  logic                   dac_clk_i,
    input  logic                   dac_rstn_i,
    input  logic                   trig_sw_i,
    input  logic                   trig_ext_i,
    input  logic [2:0]             trig_src_i,
    input  logic                   buf_we_i,
    input  logic [RSZ-1:0]         buf_addr_i,
    input  logic [DW-1:0]          buf_wdata_i,
    input  logic [RSZ+FRAC-1:0]    set_size_i,
    input  logic [RSZ+FRAC-1:0]    set_step_i,
    input  logic [RSZ+FRAC-1:0]    set_ofs_i,
    input  logic                   set_rst_i,
    input  logic                   set_wrap_i,
    input  logic                   set_interp_i,
    input  logic [DW-1:0]          set_amp_i,
    input  logic [DW-1:0]          set_dc_i,
    input  logic                   set_zero_i,
    input  logic [CYCLE_BITS-1:0]  set_ncyc_i,
    input  logic [15:0]            set_rnum_i,
    input  logic [31:0]            set_rdly_i,
    output logic signed [DW-1:0]   dac_o,
    output logic [RSZ-1:0]         buf_rpnt_o,
    output logic                   trig_done_o,
    output logic                   busy_o
);

    localparam int PW     = RSZ + FRAC;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PRODW  = DW + WGT_W + 2;
    localparam int MW     = 2 * DW + 1;

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_DELAY = ST_DELAY;

    logic                  trig;
    logic [1:0]            state;
    logic [PW-1:0]         pnt;
    logic [CYCLE_BITS-1:0] cyc_cnt;
    logic [15:0]           rep_cnt;
    logic [31:0]           dly_cnt;
    logic [TICK_W-1:0]     tick_cnt;

    asg_trig_cond u_trig (
        .clk      (dac_clk_i),
        .rst_n    (dac_rstn_i),
        .trig_sw  (trig_sw_i),
        .trig_ext (trig_ext_i),
        .trig_src (trig_src_i),
        .trig     (trig)
    );

    logic [PW:0] npnt;
    logic [PW:0] nwrap;
    logic        wrap_ev;
    logic        last_pass;

    assign npnt      = {1'b0, pnt} + {1'b0, set_step_i};
    assign nwrap     = npnt - {1'b0, set_size_i};
    assign wrap_ev   = (npnt >= {1'b0, set_size_i});
    assign last_pass = (cyc_cnt == CYCLE_BITS'(1)) && (set_ncyc_i != '0);

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            state       <= S_IDLE;
            pnt         <= '0;
            cyc_cnt     <= '0;
            rep_cnt     <= '0;
            dly_cnt     <= '0;
            tick_cnt    <= '0;
            trig_done_o <= 1'b0;
        end else begin
            trig_done_o <= 1'b0;
            if (set_rst_i) begin
                state    <= S_IDLE;
                pnt      <= set_ofs_i;
                cyc_cnt  <= '0;
                rep_cnt  <= '0;
                dly_cnt  <= '0;
                tick_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        pnt <= set_ofs_i;
                        if (trig) begin
                            state   <= S_RUN;
                            cyc_cnt <= set_ncyc_i;
                            rep_cnt <= set_rnum_i;
                        end
                    end
                    S_RUN: begin
                        if (!wrap_ev) begin
                            pnt <= npnt[PW-1:0];
                        end else if (!last_pass) begin
                            pnt <= set_wrap_i ? nwrap[PW-1:0] : set_ofs_i;
                            if (set_ncyc_i != '0)
                                cyc_cnt <= cyc_cnt - CYCLE_BITS'(1);
                        end else if (rep_cnt == '0) begin
                            state       <= S_IDLE;
                            pnt         <= set_ofs_i;
                            trig_done_o <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt - 16'd1;
                            pnt     <= set_ofs_i;
                            cyc_cnt <= set_ncyc_i;
                            if (set_rdly_i != '0) begin
                                state    <= S_DELAY;
                                dly_cnt  <= set_rdly_i;
                                tick_cnt <= '0;
                            end
                        end
                    end
                    S_DELAY: begin
                        pnt <= set_ofs_i;
                        // Leave on the tick that takes the count to zero.
                        if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
                            tick_cnt <= '0;
                            if (dly_cnt <= 32'd1) begin
                                dly_cnt <= '0;
                                state   <= S_RUN;
                                cyc_cnt <= set_ncyc_i;
                            end else begin
                                dly_cnt <= dly_cnt - 32'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy_o     = (state == S_RUN) || (state == S_DELAY);
    assign buf_rpnt_o = pnt[PW-1:FRAC];

    logic [RSZ-1:0] addr_a;
    logic [RSZ-1:0] addr_b;
    logic [RSZ:0]   a_inc;

    assign addr_a = pnt[PW-1:FRAC];
    assign a_inc  = {1'b0, addr_a} + (RSZ+1)'(1);
    assign addr_b = (a_inc >= {1'b0, set_size_i[PW-1:FRAC]}) ? set_ofs_i[PW-1:FRAC]
                                                             : a_inc[RSZ-1:0];

    logic signed [DW-1:0] mem [0:(1<<RSZ)-1];
    logic signed [DW-1:0] sa_1;
    logic signed [DW-1:0] sb_1;

    // Read-first dual read port: same-cycle write leaves old data on the read.
    always_ff @(posedge dac_clk_i) begin
        if (buf_we_i)
            mem[buf_addr_i] <= buf_wdata_i;
        sa_1 <= mem[addr_a];
        sb_1 <= mem[addr_b];
    end

    logic [WGT_W-1:0]      w_1;
    logic [WGT_W-1:0]      w_2;
    logic signed [DW:0]    diff_2;
    logic signed [DW-1:0]  sa_2;
    logic signed [DW-1:0]  sa_3;
    logic signed [PRODW-1:0] prod_3;
    logic signed [DW:0]    y_4;
    logic signed [MW-1:0]  m_5;

    logic signed [PRODW-1:0] diff_x;
    logic signed [PRODW-1:0] wgt_x;
    logic signed [MW-1:0]    y_x;
    logic signed [MW-1:0]    amp_x;
    logic signed [DW+1:0]    sum_v;
    logic signed [31:0]      sum_x;
    logic signed [31:0]      sat_val;
    logic                    unused_bits;

    assign diff_x  = {{(PRODW-DW-1){diff_2[DW]}}, diff_2};
    assign wgt_x   = {{(PRODW-WGT_W){1'b0}}, w_2};
    assign y_x     = {{(MW-DW-1){y_4[DW]}}, y_4};
    assign amp_x   = {{(MW-DW){1'b0}}, set_amp_i};
    // One guard bit above DW+1 so large gain plus offset saturates instead of wrapping.
    assign sum_v   = m_5[DW-1 +: DW+2] + {{2{set_dc_i[DW-1]}}, set_dc_i};
    assign sum_x   = {{(30-DW){sum_v[DW+1]}}, sum_v};
    assign sat_val = sat_signed(sum_x, DW);

    assign unused_bits = ^{nwrap[PW], prod_3[PRODW-1], prod_3[WGT_W-1:0],
                           m_5[DW-2:0], sat_val[31:DW]};

    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            w_1    <= '0;
            w_2    <= '0;
            diff_2 <= '0;
            sa_2   <= '0;
            sa_3   <= '0;
            prod_3 <= '0;
            y_4    <= '0;
            m_5    <= '0;
            dac_o  <= '0;
        end else begin
            w_1    <= pnt[FRAC-1 -: WGT_W];
            w_2    <= w_1;
            diff_2 <= {sb_1[DW-1], sb_1} - {sa_1[DW-1], sa_1};
            sa_2   <= sa_1;
            prod_3 <= diff_x * wgt_x;
            sa_3   <= sa_2;
            y_4    <= set_interp_i ? ({sa_3[DW-1], sa_3} + prod_3[WGT_W +: DW+1])
                                   : {sa_3[DW-1], sa_3};
            m_5    <= y_x * amp_x;
            dac_o  <= set_zero_i ? '0 : sat_val[DW-1:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_asg_interp_ch.sv
`default_nettype none
// ============================================================================
// Module   : tb_asg_interp_ch
// Brief    : Directed bench for asg_interp_ch with a queue of expected values.
//            Lockout expectations follow ASG_EXT_DEBOUNCE_EN.
// Revision : 1.0
// ============================================================================
module tb_asg_interp_ch;
    import asg_pkg::*;

    localparam int DW  = 14;
    localparam int RSZ = 14;
    localparam int FRAC = 16;
    localparam int PW  = RSZ + FRAC;
    localparam int CB  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic trig_sw = 1'b0;
    logic trig_ext = 1'b0;
    logic [2:0] trig_src = 3'd1;
    logic buf_we = 1'b0;
    logic [RSZ-1:0] buf_addr = '0;
    logic [DW-1:0] buf_wdata = '0;
    logic [PW-1:0] set_size = PW'(4 << 16);
    logic [PW-1:0] set_step = PW'(1 << 15);
    logic [PW-1:0] set_ofs = '0;
    logic set_rst = 1'b0;
    logic set_wrap = 1'b1;
    logic set_interp = 1'b1;
    logic [DW-1:0] set_amp = 14'h2000;
    logic [DW-1:0] set_dc = '0;
    logic set_zero = 1'b0;
    logic [CB-1:0] set_ncyc = 32'd1;
    logic [15:0] set_rnum = 16'd0;
    logic [31:0] set_rdly = 32'd0;
    logic signed [DW-1:0] dac;
    logic [RSZ-1:0] rpnt;
    logic done;
    logic busy;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int exp_q[$];
    int rp_q[$];

    asg_interp_ch dut (
        .dac_clk_i   (clk),
        .dac_rstn_i  (rst_n),
        .trig_sw_i   (trig_sw),
        .trig_ext_i  (trig_ext),
        .trig_src_i  (trig_src),
        .buf_we_i    (buf_we),
        .buf_addr_i  (buf_addr),
        .buf_wdata_i (buf_wdata),
        .set_size_i  (set_size),
        .set_step_i  (set_step),
        .set_ofs_i   (set_ofs),
        .set_rst_i   (set_rst),
        .set_wrap_i  (set_wrap),
        .set_interp_i(set_interp),
        .set_amp_i   (set_amp),
        .set_dc_i    (set_dc),
        .set_zero_i  (set_zero),
        .set_ncyc_i  (set_ncyc),
        .set_rnum_i  (set_rnum),
        .set_rdly_i  (set_rdly),
        .dac_o       (dac),
        .buf_rpnt_o  (rpnt),
        .trig_done_o (done),
        .busy_o      (busy)
    );

    always #4 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic wr(input int addr, input int val);
        @(negedge clk);
        buf_we = 1'b1;
        buf_addr = addr[RSZ-1:0];
        buf_wdata = val[DW-1:0];
        @(negedge clk);
        buf_we = 1'b0;
    endtask

    task automatic pulse_sw();
        @(negedge clk);
        trig_sw = 1'b1;
        @(negedge clk);
        trig_sw = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int n = 0;
        while (busy !== lvl && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(busy === lvl), 1);
    endtask

    // Waits for RUN, then compares dac samples PIPE_LAT clocks later against the queue.
    task automatic play_and_check(input string tag);
        int n;
        pulse_sw();
        wait_busy(1'b1, {tag, "_start"});
        repeat (PIPE_LAT) @(negedge clk);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            check(tag, int'(dac), exp_q.pop_front());
            @(negedge clk);
        end
    endtask

    initial begin
        int d0;
        int idx;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dac", int'(dac), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rpnt", int'(rpnt), 0);
        rst_n = 1'b1;

        wr(0, 0); wr(1, 1000); wr(2, 2000); wr(3, 3000);
        repeat (8) @(negedge clk);

        // Half-step interpolated playback, last point blends toward ofs.
        d0 = done_cnt;
        exp_q = '{0, 500, 1000, 1500, 2000, 2500, 3000, 1500, 0};
        play_and_check("interp");
        repeat (3) @(negedge clk);
        check("interp_done", done_cnt - d0, 1);
        check("interp_idle", int'(busy), 0);

        set_interp = 1'b0;
        exp_q = '{0, 0, 1000, 1000, 2000, 2000, 3000, 3000, 0};
        play_and_check("nointerp");
        repeat (3) @(negedge clk);

        // Two passes, one repetition after 3 delay ticks.
        set_step = PW'(1 << 16);
        set_ncyc = 32'd2;
        set_rnum = 16'd1;
        set_rdly = 32'd3;
        d0 = done_cnt;
        pulse_sw();
        wait_busy(1'b1, "burst_start");
        rp_q.delete();
        while (busy === 1'b1 && rp_q.size() < 2000) begin
            rp_q.push_back(int'(rpnt));
            @(negedge clk);
        end
        check("burst_len", rp_q.size(), 391);
        check("burst_done_edge", int'(done), 1);
        for (int i = 0; i < 8; i++) exp_q.push_back(i % 4);
        for (int i = 0; i < 8; i++)
            check("burst_head", (rp_q.size() > i) ? rp_q[i] : -1, exp_q.pop_front());
        for (int i = 0; i < 8; i++) exp_q.push_back(i % 4);
        for (int i = 0; i < 8; i++) begin
            idx = rp_q.size() - 8 + i;
            check("burst_tail", (idx >= 0) ? rp_q[idx] : -1, exp_q.pop_front());
        end
        repeat (3) @(negedge clk);
        check("burst_done_cnt", done_cnt - d0, 1);

        // Scaling and saturation at pnt = ofs = 0 while idle.
        set_ncyc = 32'd1;
        set_rnum = 16'd0;
        set_rdly = 32'd0;
        wr(0, 8191);
        set_amp = 14'h3FFF;
        set_dc = 14'd8191;
        repeat (8) @(negedge clk);
        check("sat_pos", int'(dac), 8191);
        wr(0, -8192);
        set_dc = 14'h2000;
        repeat (8) @(negedge clk);
        check("sat_neg", int'(dac), -8192);
        set_amp = 14'h1000;
        set_dc = 14'd100;
        repeat (8) @(negedge clk);
        check("half_gain", int'(dac), -3996);
        set_zero = 1'b1;
        repeat (8) @(negedge clk);
        check("zero", int'(dac), 0);
        set_zero = 1'b0;

        // Read-first table write: old data must flow through the full latency.
        set_amp = 14'h2000;
        set_dc = '0;
        wr(0, 0);
        repeat (8) @(negedge clk);
        wr(0, 777);
        repeat (5) @(negedge clk);
        check("rdfirst_old", int'(dac), 0);
        @(negedge clk);
        check("rdfirst_new", int'(dac), 777);

        // Level reset during DELAY wins over a simultaneous sw trigger.
        set_ofs = PW'(1 << 16);
        set_rnum = 16'd1;
        set_rdly = 32'd3;
        pulse_sw();
        wait_busy(1'b1, "rst_start");
        repeat (50) @(negedge clk);
        d0 = done_cnt;
        set_rst = 1'b1;
        trig_sw = 1'b1;
        @(negedge clk);
        set_rst = 1'b0;
        trig_sw = 1'b0;
        check("rst_busy_mid", int'(busy), 0);
        check("rst_pnt", int'(rpnt), 1);
        repeat (5) @(negedge clk);
        check("rst_still_idle", int'(busy), 0);
        check("rst_no_done", done_cnt - d0, 0);

        // Source off ignores the sw trigger.
        set_ofs = '0;
        set_rnum = 16'd0;
        set_rdly = 32'd0;
        trig_src = 3'd0;
        pulse_sw();
        repeat (5) @(negedge clk);
        check("src_off", int'(busy), 0);

        // External rising edges 100 clocks apart.
        trig_src = 3'd2;
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        trig_ext = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ext_lat_pre", int'(busy), 0);
        @(negedge clk);
        check("ext_lat", int'(busy), 1);
        repeat (17) @(negedge clk);
        trig_ext = 1'b0;
        repeat (80) @(negedge clk);
        trig_ext = 1'b1;
        repeat (20) @(negedge clk);
        trig_ext = 1'b0;
        repeat (30) @(negedge clk);
`ifdef ASG_EXT_DEBOUNCE_EN
        check("ext_edges", done_cnt - d0, 1);
`else
        check("ext_edges", done_cnt - d0, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
